param_sync_fifo: RTL and testbench

//   Parametrised single-clock FIFO. Next generation of the team's FIFO block.

---
 rtl/param_sync_fifo_if.sv | 32 +++
 rtl/param_sync_fifo.sv | 113 +++++++++++
 tb/tb_param_sync_fifo.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/param_sync_fifo_if.sv
// Producer/consumer bundle for param_sync_fifo; master drives requests, slave is the FIFO.
// No latency of its own; full/empty/count carry the backpressure back to the master.
interface param_sync_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
);
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  rd_en;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, data_in, rd_en, clr_err,
      input  data_out, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr_en, data_in, rd_en, clr_err,
      output data_out, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO, full DEPTH usable; read data 1 cycle after rd_en (FWFT=0) or head shown directly (FWFT=1).
// Writes while full and reads while empty are dropped and latched into sticky overflow/underflow flags.
module param_sync_fifo #(
   parameter int DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 5,
   parameter int ALMOST_FULL_TH  = (2 ** ADDR_WIDTH) - 2,
   parameter int ALMOST_EMPTY_TH = 2,
   parameter bit FWFT            = 1'b0
) (
   input logic               clk,
   input logic               reset,
   param_sync_fifo_if.slave  fifo
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0] AF_TH   = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
   localparam logic [ADDR_WIDTH:0] AE_TH   = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);

   if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH - 1) begin : g_bad_af
      $error("param_sync_fifo: ALMOST_FULL_TH must lie in 1..DEPTH-1");
   end
   if (ALMOST_EMPTY_TH < 1 || ALMOST_EMPTY_TH > DEPTH - 1) begin : g_bad_ae
      $error("param_sync_fifo: ALMOST_EMPTY_TH must lie in 1..DEPTH-1");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   occ;
   logic                  ovf;
   logic                  udf;
   logic                  is_full;
   logic                  is_empty;
   logic                  wr_acc;
   logic                  rd_acc;

   // The extra pointer bit separates "wrapped once" (full) from "equal" (empty).
   assign is_empty = (wr_ptr == rd_ptr);
   assign is_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
   assign wr_acc   = fifo.wr_en && !is_full;
   assign rd_acc   = fifo.rd_en && !is_empty;

   always_ff @(posedge clk) begin
      if (reset && wr_acc) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= fifo.data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         unique case ({wr_acc, rd_acc})
            2'b10:   occ <= occ + PTR_ONE;
            2'b01:   occ <= occ - PTR_ONE;
            default: occ <= occ;
         endcase
         // A fresh error in the same cycle as clr_err must not be lost.
         if (fifo.wr_en && is_full) begin
            ovf <= 1'b1;
         end else if (fifo.clr_err) begin
            ovf <= 1'b0;
         end
         if (fifo.rd_en && is_empty) begin
            udf <= 1'b1;
         end else if (fifo.clr_err) begin
            udf <= 1'b0;
         end
      end
   end

   if (FWFT) begin : g_fwft
      assign fifo.data_out = mem[rd_ptr[ADDR_WIDTH-1:0]];
      assign fifo.rd_valid = !is_empty;
   end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  vld_q;

      always_ff @(posedge clk) begin
         if (!reset) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
         end else begin
            vld_q <= rd_acc;
            if (rd_acc) begin
               dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
         end
      end

      assign fifo.data_out = dout_q;
      assign fifo.rd_valid = vld_q;
   end

   assign fifo.full         = is_full;
   assign fifo.empty        = is_empty;
   assign fifo.count        = occ;
   assign fifo.almost_full  = (occ >= AF_TH);
   assign fifo.almost_empty = (occ <= AE_TH);
   assign fifo.overflow     = ovf;
   assign fifo.underflow    = udf;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Drives a registered-read and an FWFT instance with identical traffic and checks both
// against a queue-based reference model; registered read data is checked by a separate monitor.
module tb_param_sync_fifo;
   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int DEPTH = 32;
   localparam int AF    = 30;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [DW-1:0] data_in;
   logic          rd_en;
   logic          clr_err;

   always #5 clk = ~clk;

   param_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
   param_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

   assign bus0.wr_en   = wr_en;
   assign bus0.data_in = data_in;
   assign bus0.rd_en   = rd_en;
   assign bus0.clr_err = clr_err;
   assign bus1.wr_en   = wr_en;
   assign bus1.data_in = data_in;
   assign bus1.rd_en   = rd_en;
   assign bus1.clr_err = clr_err;

   param_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF),
                     .ALMOST_EMPTY_TH(AE), .FWFT(1'b0))
      dut0 (.clk(clk), .reset(reset), .fifo(bus0));

   param_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF),
                     .ALMOST_EMPTY_TH(AE), .FWFT(1'b1))
      dut1 (.clk(clk), .reset(reset), .fifo(bus1));

   // Reference model: stored words, sticky flags, and words owed by the registered read port.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp0[$];
   bit            m_ovf;
   bit            m_udf;
   bit            exp_vld;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      int n;
      n = mq.size();
      chk("count0", 32'(bus0.count), n);
      chk("count1", 32'(bus1.count), n);
      chk("full", 32'(bus0.full), 32'(n == DEPTH));
      chk("empty", 32'(bus0.empty), 32'(n == 0));
      chk("almost_full", 32'(bus0.almost_full), 32'(n >= AF));
      chk("almost_empty", 32'(bus0.almost_empty), 32'(n <= AE));
      chk("overflow", 32'(bus0.overflow), 32'(m_ovf));
      chk("underflow", 32'(bus0.underflow), 32'(m_udf));
      chk("overflow1", 32'(bus1.overflow), 32'(m_ovf));
      chk("underflow1", 32'(bus1.underflow), 32'(m_udf));
      chk("rd_valid0", 32'(bus0.rd_valid), 32'(exp_vld));
      chk("fwft_valid", 32'(bus1.rd_valid), 32'(n != 0));
      if (n != 0) chk("fwft_data", 32'(bus1.data_out), 32'(mq[0]));
   endtask

   // One clock of traffic; the model applies the accept rules to the pre-edge occupancy.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
      bit full_m;
      bit empty_m;
      reset   = 1'b1;
      wr_en   = w;
      data_in = d;
      rd_en   = r;
      clr_err = c;
      full_m  = (mq.size() == DEPTH);
      empty_m = (mq.size() == 0);
      exp_vld = r && !empty_m;
      if (r && !empty_m) exp0.push_back(mq.pop_front());
      if (w && !full_m) mq.push_back(d);
      if (w && full_m) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (r && empty_m) m_udf = 1'b1;
      else if (c) m_udf = 1'b0;
      @(negedge clk);
      check_state();
   endtask

   task automatic do_reset(input int cycles);
      reset   = 1'b0;
      wr_en   = 1'($urandom);
      data_in = DW'($urandom);
      rd_en   = 1'($urandom);
      clr_err = 1'b0;
      repeat (cycles) @(negedge clk);
      mq.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      exp_vld = 1'b0;
      check_state();
      chk("reset_data_out0", 32'(bus0.data_out), 32'h0);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (bus0.rd_valid === 1'b1) begin
            if (exp0.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_data_unexpected: got %0h with rd_valid, expected no word at %0t",
                        bus0.data_out, $time);
            end else begin
               chk("rd_data", 32'(bus0.data_out), 32'(exp0.pop_front()));
            end
         end
      end
   end

   initial begin : stimulus
      wr_en   = 1'b0;
      data_in = '0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      do_reset(2);

      // Fill to exactly DEPTH, overflow attempt, then drain in order.
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Wrap-around of both pointers.
      for (int i = 0; i < 20; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Simultaneous read/write at mid occupancy and at full.
      for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      step(1'b1, DW'($urandom), 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // FWFT head visibility, underflow, set-beats-clear, then clear.
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      chk("fwft_a5", 32'(bus1.data_out), 32'hA5);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Reset in the middle of random traffic.
      for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom), 1'b0);
      do_reset(2);

      // Random phases with varying write/read pressure.
      for (int p = 0; p < 8; p++) begin
         int wp;
         int rp;
         wp = $urandom_range(10, 90);
         rp = $urandom_range(10, 90);
         for (int i = 0; i < 250; i++) begin
            step(1'($urandom_range(0, 99) < wp), DW'($urandom),
                 1'($urandom_range(0, 99) < rp), 1'($urandom_range(0, 99) < 3));
         end
      end
      while (mq.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("exp0_drained", 32'(exp0.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
